// File: rtl/rect_fill_engine.sv
// Rectangle fill rasterizer: clips a rectangle command to the screen, then
// walks it in raster order (x fastest), offering one pixel write per cycle
// on a valid/ready port toward the framebuffer write side.
module rect_fill_engine #(
  parameter int WIDTH        = 8,
  parameter int COLOUR_WIDTH = 3,
  parameter int SCREEN_X_MAX = 159,
  parameter int SCREEN_Y_MAX = 119
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WIDTH-1:0]        x0,
  input  logic [WIDTH-1:0]        y0,
  input  logic [WIDTH-1:0]        x_span,
  input  logic [WIDTH-1:0]        y_span,
  input  logic [COLOUR_WIDTH-1:0] colour,
  output logic                    busy,
  output logic                    done,
  output logic [WIDTH-1:0]        px,
  output logic [WIDTH-1:0]        py,
  output logic [COLOUR_WIDTH-1:0] pcolour,
  output logic                    pvalid,
  input  logic                    pready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLIP = 2'd1,
    DRAW = 2'd2,
    DONE = 2'd3
  } state_t;

  // Screen limits carried one bit wider so origin+span never wraps.
  localparam logic [WIDTH:0] X_MAX_W = (WIDTH+1)'(SCREEN_X_MAX);
  localparam logic [WIDTH:0] Y_MAX_W = (WIDTH+1)'(SCREEN_Y_MAX);

  state_t state_q, state_d;

  // Latched command
  logic [WIDTH-1:0]        x0_q, y0_q, x_span_q, y_span_q;
  logic [COLOUR_WIDTH-1:0] colour_q;

  // Clipped inclusive extents and running offsets
  logic [WIDTH:0]          xs_q, ys_q;
  logic [WIDTH-1:0]        xo_q, yo_q;

  // Clip arithmetic, evaluated while in CLIP
  logic                    off_screen;
  logic [WIDTH:0]          x_room, y_room;
  logic [WIDTH:0]          xs_clip, ys_clip;

  // Scan bookkeeping, evaluated while in DRAW
  logic                    transfer;
  logic                    row_end;
  logic                    last_pixel;

  assign off_screen = ({1'b0, x0_q} > X_MAX_W) || ({1'b0, y0_q} > Y_MAX_W);
  // Room left to the screen edge; only meaningful when the origin is on screen.
  assign x_room     = X_MAX_W - {1'b0, x0_q};
  assign y_room     = Y_MAX_W - {1'b0, y0_q};
  assign xs_clip    = ({1'b0, x_span_q} > x_room) ? x_room : {1'b0, x_span_q};
  assign ys_clip    = ({1'b0, y_span_q} > y_room) ? y_room : {1'b0, y_span_q};

  assign transfer   = (state_q == DRAW) && pready;
  assign row_end    = ({1'b0, xo_q} == xs_q);
  assign last_pixel = row_end && ({1'b0, yo_q} == ys_q);

  // State register.
  // NOTE: sequential state is always updated with non-blocking assignments so
  // every register samples pre-edge values, regardless of block ordering.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start)                   state_d = CLIP;
      CLIP: state_d = off_screen ? DONE : DRAW;
      DRAW: if (transfer && last_pixel)  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Command latch, clip results and raster offsets.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x0_q     <= '0;
      y0_q     <= '0;
      x_span_q <= '0;
      y_span_q <= '0;
      colour_q <= '0;
      xs_q     <= '0;
      ys_q     <= '0;
      xo_q     <= '0;
      yo_q     <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            x0_q     <= x0;
            y0_q     <= y0;
            x_span_q <= x_span;
            y_span_q <= y_span;
            colour_q <= colour;
          end
        end
        CLIP: begin
          xs_q <= xs_clip;
          ys_q <= ys_clip;
          xo_q <= '0;
          yo_q <= '0;
        end
        DRAW: begin
          if (transfer && !last_pixel) begin
            if (!row_end) begin
              xo_q <= xo_q + WIDTH'(1);
            end else begin
              xo_q <= '0;
              yo_q <= yo_q + WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only, so they hold steady under
  // backpressure and fall with the state register on an asynchronous reset.
  always_comb begin
    busy    = (state_q == CLIP) || (state_q == DRAW);
    done    = (state_q == DONE);
    pvalid  = (state_q == DRAW);
    px      = '0;
    py      = '0;
    pcolour = '0;
    if (state_q == DRAW) begin
      px      = x0_q + xo_q;
      py      = y0_q + yo_q;
      pcolour = colour_q;
    end
  end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: single pixel, small fill, stall,
// right/bottom clipping, off-screen origin, start re-pulse and mid-draw reset.
module tb_rect_fill_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] x0 = '0, y0 = '0, x_span = '0, y_span = '0;
  logic [2:0] colour = '0;
  logic       busy, done, pvalid;
  logic [7:0] px, py;
  logic [2:0] pcolour;
  logic       pready = 1'b1;

  int checks = 0;
  int errors = 0;

  rect_fill_engine #(
    .WIDTH(8), .COLOUR_WIDTH(3), .SCREEN_X_MAX(159), .SCREEN_Y_MAX(119)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .x_span(x_span), .y_span(y_span), .colour(colour),
    .busy(busy), .done(done), .px(px), .py(py), .pcolour(pcolour),
    .pvalid(pvalid), .pready(pready)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  function automatic int pack_pixel(input int x, input int y, input int c);
    return (x << 16) | (y << 4) | c;
  endfunction

  // Issue one command and follow it to its done pulse. Expected pixels come
  // from an on-screen filter over the unclipped rectangle; exp_n is the
  // hand-computed pixel count; stall_idx/stall_len hold pready low on a pixel.
  task automatic run_rect(input string name, input int ax0, input int ay0,
                          input int axs, input int ays, input int acol,
                          input int exp_n, input int stall_idx,
                          input int stall_len, input bit repulse);
    int exp_q[$];
    int idx = 0;
    int stalls = 0;
    int k = 0;
    int done_k = -1;
    for (int y = ay0; y <= ay0 + ays; y++)
      for (int x = ax0; x <= ax0 + axs; x++)
        if (x <= 159 && y <= 119) exp_q.push_back(pack_pixel(x, y, acol));

    @(negedge clock);
    x0 = 8'(ax0); y0 = 8'(ay0); x_span = 8'(axs); y_span = 8'(ays);
    colour = 3'(acol); start = 1'b1; pready = 1'b1;
    @(negedge clock);
    // Command inputs are free to change once accepted.
    start = 1'b0; x0 = 8'd1; y0 = 8'd2; x_span = 8'd9; y_span = 8'd9; colour = 3'd7;
    check({name, "_clip_busy"}, int'(busy), 1);
    check({name, "_clip_pvalid"}, int'(pvalid), 0);

    while (done_k < 0 && k < 400) begin
      @(negedge clock);
      k++;
      if (done) begin
        done_k = k;
        check({name, "_done_pvalid"}, int'(pvalid), 0);
        check({name, "_done_busy"}, int'(busy), 0);
      end else if (pvalid) begin
        if (idx < exp_q.size())
          check({name, "_pixel"}, pack_pixel(int'(px), int'(py), int'(pcolour)), exp_q[idx]);
        else
          check({name, "_extra_pixel"}, idx, exp_q.size());
        if (idx == stall_idx && stalls < stall_len) begin
          pready = 1'b0;
          stalls++;
        end else begin
          pready = 1'b1;
          idx++;
        end
      end else begin
        pready = 1'b1;
      end
      if (repulse && k == 3) begin
        start = 1'b1; x0 = 8'd3; y0 = 8'd3; x_span = 8'd0; y_span = 8'd0; colour = 3'd1;
      end
      if (repulse && k == 4) start = 1'b0;
    end

    check({name, "_done_cycle"}, done_k, 1 + exp_n + stall_len);
    check({name, "_count"}, idx, exp_n);
    pready = 1'b1;
    @(negedge clock);
    check({name, "_after_done"}, int'(done), 0);
    check({name, "_after_busy"}, int'(busy), 0);
    check({name, "_after_pvalid"}, int'(pvalid), 0);
  endtask

  initial begin
    // Reset state while reset is held low.
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pvalid", int'(pvalid), 0);
    check("rst_px", int'(px), 0);
    check("rst_py", int'(py), 0);
    check("rst_pcolour", int'(pcolour), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    run_rect("single", 5, 7, 0, 0, 3, 1, -1, 0, 1'b0);
    run_rect("fill3x2", 10, 20, 2, 1, 5, 6, -1, 0, 1'b0);
    run_rect("stall", 10, 20, 2, 1, 5, 6, 1, 3, 1'b0);
    run_rect("clip_br", 158, 118, 4, 4, 2, 4, -1, 0, 1'b0);
    run_rect("nowrap", 150, 0, 255, 0, 6, 10, -1, 0, 1'b0);
    run_rect("offscreen", 200, 0, 3, 3, 1, 0, -1, 0, 1'b0);
    run_rect("repulse", 10, 20, 2, 1, 4, 6, -1, 0, 1'b1);

    // Asynchronous reset in the middle of a draw.
    @(negedge clock);
    x0 = 8'd10; y0 = 8'd20; x_span = 8'd2; y_span = 8'd1; colour = 3'd5;
    start = 1'b1; pready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("midrst_drawing", int'(pvalid), 1);
    #2 reset = 1'b0;
    #1;
    check("midrst_pvalid", int'(pvalid), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_px", int'(px), 0);
    @(negedge clock);
    reset = 1'b1; pready = 1'b1;
    @(negedge clock);
    check("postrst_busy", int'(busy), 0);
    check("postrst_pvalid", int'(pvalid), 0);
    @(negedge clock);
    check("postrst_idle_busy", int'(busy), 0);
    run_rect("after_rst", 0, 0, 0, 0, 7, 1, -1, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rect_fill_engine.md
Name: rect_fill_engine

Overview:
Hardware rectangle rasterizer that sits directly upstream of the framebuffer/VGA write port in the drawing pipeline. It accepts a rectangle command with origin, inclusive spans and colour, clips it to the screen, then scans it in raster order, x fastest, emitting one pixel write per accepted transfer on a valid/ready interface. It is the command-level consumer of the x/y grid scan that generates pixel offsets, and it is used for screen clear and HUD panel fills.

Parameters:
WIDTH, 8, coordinate/span bit width
COLOUR_WIDTH, 3, pixel colour bit width
SCREEN_X_MAX, 159, last valid screen column (inclusive)
SCREEN_Y_MAX, 119, last valid screen row (inclusive)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  command strobe, sampled only in IDLE
x0  input  WIDTH  rectangle origin column
y0  input  WIDTH  rectangle origin row
x_span  input  WIDTH  inclusive width minus one (0 = 1 column)
y_span  input  WIDTH  inclusive height minus one (0 = 1 row)
colour  input  COLOUR_WIDTH  fill colour
busy  output  1  high in CLIP and DRAW
done  output  1  one-cycle pulse on completion
px  output  WIDTH  pixel column
py  output  WIDTH  pixel row
pcolour  output  COLOUR_WIDTH  pixel colour
pvalid  output  1  pixel write valid
pready  input  1  downstream accepts pixel

Behaviour:
- Reset (reset=0, async): state=IDLE. busy, done, pvalid, px, py and pcolour are 0. Internal offsets and latched command are 0. Deassertion takes effect at the next clock edge. Reset mid-DRAW drops pvalid immediately and discards the command.
- States: IDLE, CLIP, DRAW, DONE.
- IDLE: when start=1 at an edge, latch x0, y0, x_span, y_span and colour, then go to CLIP. Command inputs may change after that edge.
- CLIP (exactly 1 cycle):
  - If x0>SCREEN_X_MAX or y0>SCREEN_Y_MAX, go to DONE and emit no pixels.
  - Otherwise compute xs=min(x_span, SCREEN_X_MAX-x0) and ys=min(y_span, SCREEN_Y_MAX-y0) in WIDTH+1-bit arithmetic. No wrap is allowed: x0+x_span overflowing WIDTH bits clips, it does not wrap. Clear the offsets xo=yo=0 and go to DRAW.
- DRAW: pvalid=1 and px=x0+xo, py=y0+yo, pcolour=colour_latched.
  - These outputs come from registered state. They must be stable while pvalid=1 and pready=0.
  - A transfer occurs on an edge with pvalid&pready. On a transfer: if xo<xs, xo++; else xo=0 and yo++. If xo==xs and yo==ys, the transfer is the last one, and the next state is DONE with pvalid=0 next cycle.
- DONE (1 cycle): done=1, busy=0, then go to IDLE. A start during DONE is ignored. A new command is accepted only in IDLE, so the minimum gap between the done pulse and the next start is 1 cycle.
- start in CLIP, DRAW or DONE is ignored, and the latched command is unaffected.
- Latency: start edge E0, then CLIP at E0..E1, then first pvalid in the cycle after E1. With pready held at 1, an N-pixel rectangle completes its last transfer at edge E1+N. done is high for the cycle after that edge.
- Pixel count = (xs+1)*(ys+1). No pixel is ever emitted outside 0..SCREEN_X_MAX or 0..SCREEN_Y_MAX. Each pixel is emitted exactly once.

Test Plan:
- Single pixel: x0=5, y0=7, spans 0, colour=3, pready=1. Required: exactly one pixel (5,7,3) in the cycle after E1; done pulse one cycle later; busy low afterwards.
- 3x2 fill: x0=10, y0=20, x_span=2, y_span=1, pready=1. Required: pixel order (10,20),(11,20),(12,20),(10,21),(11,21),(12,21); exactly 6 transfers; done after edge E7.
- Backpressure: same 3x2 command, pready low for 3 cycles on the 2nd pixel. Required: px/py hold at (11,20) throughout the stall; sequence otherwise unchanged; done delayed by exactly 3 cycles.
- Right/bottom clip:
  - x0=158, y0=118, x_span=4, y_span=4. Required: only (158,118),(159,118),(158,119),(159,119).
  - x0=150, x_span=255. Required: no wrap; columns 150..159 only.
- Off-screen: x0=200, y0=0. Required: CLIP then DONE; pvalid never asserts; done pulse in the cycle after E1.
- Control hazards:
  - start re-pulsed with new operands during DRAW. Required: ignored; the original rectangle completes.
  - reset=0 asserted mid-DRAW. Required: pvalid, busy and done drop to 0 immediately, without waiting for a clock; state is IDLE after release.
